// File: rtl/spi_sram_pkg.sv
// spi_sram_pkg: shared opcodes, frame size, FSM state codes and requester helpers
package spi_sram_pkg;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam int         FRAME_BITS = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_GRANT = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_DONE  = 3'd3;
    localparam state_t ST_GUARD = 3'd4;

    typedef logic req_idx_t;

    function automatic logic [1:0] onehot(input req_idx_t i);
        return i ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/spi_sram_shifter.sv
// spi_sram_shifter: mode-0 serialiser for one 32-bit byte-mode SRAM frame
module spi_sram_shifter
    import spi_sram_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  done,
    output logic [7:0]            rx_byte,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso
);

    logic                  r_active;
    logic                  r_phase;
    logic [15:0]           r_div;
    logic [5:0]            r_bits;
    logic [FRAME_BITS-1:0] r_tx;
    logic [7:0]            r_rx;
    logic                  w_half_end;

    assign w_half_end = r_active && (r_div == 16'(CLK_DIV - 1));
    assign done       = w_half_end && r_phase && (r_bits == 6'(FRAME_BITS - 1));
    assign sck        = r_active && r_phase;
    assign mosi       = r_active && r_tx[FRAME_BITS-1];
    assign rx_byte    = r_rx;

    // Half-period divider, bit counter, tx shift at end of high half, rx sample at start of high half
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_active <= 1'b0;
            r_phase  <= 1'b0;
            r_div    <= '0;
            r_bits   <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_phase  <= 1'b0;
            r_div    <= '0;
            r_bits   <= '0;
            r_tx     <= frame;
        end else if (r_active) begin
            r_div <= w_half_end ? '0 : r_div + 16'd1;
            if (r_phase && r_div == '0)
                r_rx <= {r_rx[6:0], miso};
            if (w_half_end) begin
                r_phase <= !r_phase;
                if (r_phase) begin
                    r_tx   <= r_tx << 1;
                    r_bits <= r_bits + 6'd1;
                end
                if (done)
                    r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_sram_arb_ctrl.sv
// spi_sram_arb_ctrl: round-robin two-requester arbiter sequencing byte frames to a 23LC512
module spi_sram_arb_ctrl
    import spi_sram_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int ADDR_W  = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_we,
    input  logic [31:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic [1:0]  req_gnt,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic        spi_sck,
    output logic        spi_csn,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    if (CLK_DIV < 1) begin : g_div_check
        $error("spi_sram_arb_ctrl: CLK_DIV must be >= 1");
    end

    state_t               r_state;
    req_idx_t             r_win;
    req_idx_t             r_rr_last;
    logic                 r_we;
    logic [15:0]          r_gcnt;
    logic [7:0]           r_rdata;
    req_idx_t             w_pick;
    logic [ADDR_W-1:0]    w_addr;
    logic [7:0]           w_wdata;
    logic                 w_we;
    logic [FRAME_BITS-1:0] w_frame;
    logic                 w_done;
    logic [7:0]           w_rx;
    logic [7:0]           w_rd;

    assign w_pick    = &req_valid ? !r_rr_last : req_valid[1];
    assign w_we      = req_we[r_win];
    assign w_addr    = r_win ? req_addr[16 +: ADDR_W] : req_addr[0 +: ADDR_W];
    assign w_wdata   = r_win ? req_wdata[15:8] : req_wdata[7:0];
    assign w_frame   = {w_we ? CMD_WRITE : CMD_READ, w_addr, w_we ? w_wdata : 8'h00};
    assign w_rd      = r_we ? 8'h00 : w_rx;
    assign req_gnt   = (r_state == ST_GRANT) ? onehot(r_win) : 2'b00;
    assign rsp_valid = (r_state == ST_DONE) ? onehot(r_win) : 2'b00;
    assign rsp_rdata = (r_state == ST_DONE) ? w_rd : r_rdata;
    assign busy      = r_state != ST_IDLE;
    assign spi_csn   = r_state != ST_SHIFT;

    spi_sram_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .start   (r_state == ST_GRANT),
        .frame   (w_frame),
        .done    (w_done),
        .rx_byte (w_rx),
        .sck     (spi_sck),
        .mosi    (spi_mosi),
        .miso    (spi_miso)
    );

    // Frame sequencing; DONE is the first csn-high cycle of the inter-frame gap, GUARD supplies the rest
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= ST_IDLE;
            r_win     <= 1'b0;
            r_rr_last <= 1'b1;
            r_we      <= 1'b0;
            r_gcnt    <= '0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (|req_valid) begin
                    r_win   <= w_pick;
                    r_state <= ST_GRANT;
                end
                ST_GRANT: begin
                    r_we      <= w_we;
                    r_rr_last <= r_win;
                    r_state   <= ST_SHIFT;
                end
                ST_SHIFT: if (w_done) r_state <= ST_DONE;
                ST_DONE: begin
                    r_rdata <= w_rd;
                    r_gcnt  <= '0;
                    r_state <= ST_GUARD;
                end
                ST_GUARD: if (r_gcnt == 16'(2 * CLK_DIV - 2)) r_state <= ST_IDLE;
                          else r_gcnt <= r_gcnt + 16'd1;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
